// File: rtl/cartoon_frame_capture.sv
// cartoon_frame_capture: grabs one active frame of the cartoon filter stream,
// quantizes every pixel to RGB332 and writes 4 pixels per 36-bit ZBT word.
// Handshake: there is no back-pressure. mem_we is a one-cycle write strobe and
// mem_addr/mem_data are valid in exactly the cycle mem_we is high.
module cartoon_frame_capture #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter logic [18:0] BASE_ADDR = 19'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [23:0] rgb_in,
  input  logic        capture_req,
  input  logic        abort,
  output logic [18:0] mem_addr,
  output logic [35:0] mem_data,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [10:0] LP_H_ACTIVE = 11'(H_ACTIVE);
  localparam logic [9:0]  LP_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [10:0] LP_H_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  LP_V_LAST   = 10'(V_ACTIVE - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pack;
  logic        w_active;
  logic        w_last;
  logic [1:0]  w_slot;
  logic [7:0]  w_q;
  logic        w_frame_start;
  logic        w_pack_en;
  logic        w_emit;
  logic        w_unused_rgb;

  assign w_active     = (hcount < LP_H_ACTIVE) && (vcount < LP_V_ACTIVE);
  assign w_last       = w_active && (hcount == LP_H_LAST) && (vcount == LP_V_LAST);
  assign w_slot       = hcount[1:0];
  // RGB332 by truncation: top 3 bits of R and G, top 2 bits of B.
  assign w_q          = {rgb_in[23:21], rgb_in[15:13], rgb_in[7:6]};
  assign w_unused_rgb = ^{rgb_in[20:16], rgb_in[12:8], rgb_in[5:0]};
  assign dbg_state    = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and per-pixel control decode; abort overrides everything.
  always_comb begin
    w_next        = r_state;
    w_frame_start = 1'b0;
    w_pack_en     = 1'b0;
    w_emit        = 1'b0;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (capture_req) w_next = S_ARMED;
        end
        S_ARMED: begin
          if (w_active && (hcount == 11'd0) && (vcount == 10'd0)) begin
            w_next        = S_CAPTURE;
            w_frame_start = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (w_active) begin
            w_pack_en = 1'b1;
            if (w_slot == 2'd3) w_emit = 1'b1;
            if (w_last) w_next = S_DONE;
          end
        end
        S_DONE: begin
          if (capture_req) w_next = S_ARMED;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Write port, status flags and pixel packing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr <= BASE_ADDR;
      mem_data <= 36'd0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r_pack   <= 32'd0;
    end else begin
      mem_we <= w_emit;
      busy   <= (w_next == S_ARMED) || (w_next == S_CAPTURE);
      done   <= (w_next == S_DONE);
      // The slot-3 pixel goes straight into the outgoing word.
      if (w_emit) mem_data <= {4'h0, r_pack[31:8], w_q};
      // Frame start rewinds; otherwise advance once a strobe has been issued.
      if (w_frame_start)  mem_addr <= BASE_ADDR;
      else if (mem_we)    mem_addr <= mem_addr + 19'd1;
      // A slot-0 pixel opens a fresh group, dropping stale bytes.
      if (abort) begin
        r_pack <= 32'd0;
      end else if (w_frame_start) begin
        r_pack <= {w_q, 24'd0};
      end else if (w_pack_en) begin
        case (w_slot)
          2'd0:    r_pack        <= {w_q, 24'd0};
          2'd1:    r_pack[23:16] <= w_q;
          2'd2:    r_pack[15:8]  <= w_q;
          default: r_pack        <= 32'd0;
        endcase
      end
    end
  end

endmodule
